moving_avg_filter: RTL

//  Parametrised stereo moving-average (boxcar FIR) filter for the audio path.
//  It sits between the audio_codec read side and write side.
//  It keeps a circular history of the last 2**LOG2_DEPTH samples per channel and a running sum.
//  It emits sum >>> LOG2_DEPTH per accepted sample pair, with valid/ready handshakes on both sides.
//  A bypass mode passes samples through while history keeps updating.

---
 rtl/moving_avg_filter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/moving_avg_filter.sv
// moving_avg_filter: stereo boxcar FIR over the last 2**LOG2_DEPTH pairs
// audio path filter between codec read and write sides
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     input pair handshake
//   in_left/in_right      signed input samples
//   bypass                captured at accept; 1 passes the input through
//   out_valid/out_ready   result handshake
//   out_left/out_right    signed results
//   fill_count            samples since clear, saturating at DEPTH
module moving_avg_filter #(
  parameter int WIDTH      = 24,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_left,
  input  logic [WIDTH-1:0]      in_right,
  input  logic                  bypass,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_left,
  output logic [WIDTH-1:0]      out_right,
  output logic [LOG2_DEPTH:0]   fill_count
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = WIDTH + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH-1:0] PTR_MAX = '1;
  localparam logic [LOG2_DEPTH:0] FILL_MAX =
    (LOG2_DEPTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    CLEAR, IDLE, CALC, HOLD
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]      hist_l [DEPTH];
  logic [WIDTH-1:0]      hist_r [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] clr_ptr;
  logic [WIDTH-1:0]      new_l, new_r;
  logic [WIDTH-1:0]      old_l, old_r;
  logic                  byp;
  logic [SW-1:0]         sum_l, sum_r;
  logic [SW-1:0]         sum_l_nxt, sum_r_nxt;
  logic                  accept;

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  // Sign-extended so the window sum is exact for any DEPTH.
  assign sum_l_nxt = sum_l
    + {{LOG2_DEPTH{new_l[WIDTH-1]}}, new_l}
    - {{LOG2_DEPTH{old_l[WIDTH-1]}}, old_l};
  assign sum_r_nxt = sum_r
    + {{LOG2_DEPTH{new_r[WIDTH-1]}}, new_r}
    - {{LOG2_DEPTH{old_r[WIDTH-1]}}, old_r};

  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      CLEAR: if (clr_ptr == PTR_MAX) state_nxt = IDLE;
      IDLE:  if (in_valid) state_nxt = CALC;
      CALC:  state_nxt = HOLD;
      HOLD:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  // History RAM plus the accept-time capture; no reset needed,
  // CLEAR rewrites every entry before the first accept.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      hist_l[clr_ptr] <= '0;
      hist_r[clr_ptr] <= '0;
    end else if (state == CALC) begin
      hist_l[wr_ptr] <= new_l;
      hist_r[wr_ptr] <= new_r;
    end
    if (accept) begin
      new_l <= in_left;
      new_r <= in_right;
      byp   <= bypass;
      old_l <= hist_l[wr_ptr];
      old_r <= hist_r[wr_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_l      <= '0;
      sum_r      <= '0;
      wr_ptr     <= '0;
      clr_ptr    <= '0;
      fill_count <= '0;
      out_left   <= '0;
      out_right  <= '0;
    end else begin
      if (state == CLEAR)
        clr_ptr <= clr_ptr + LOG2_DEPTH'(1);
      if (state == CALC) begin
        sum_l  <= sum_l_nxt;
        sum_r  <= sum_r_nxt;
        wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
        if (fill_count != FILL_MAX)
          fill_count <= fill_count + (LOG2_DEPTH+1)'(1);
        // Upper slice of the sum = arithmetic shift (floor).
        out_left  <= byp ? new_l
                         : sum_l_nxt[SW-1:LOG2_DEPTH];
        out_right <= byp ? new_r
                         : sum_r_nxt[SW-1:LOG2_DEPTH];
      end
    end
  end

endmodule
